mfc_unpack: RTL and testbench
=============================

// Module: mfc_unpack
// PURPOSE
//  Frame-to-stream serializer for 12-coefficient MFCC feature frames.
//  Accepts a packed OWIDTH-bit frame (coef k in bits [k*MFCBIT +: MFCBIT]) over valid/ready.
//  Emits the coefficients as a dv-strobed word burst, which the frame packer downstream can capture.
//  Used for loopback tests and to replay stored feature frames into the packer/classifier path.
// PARAMETERS
//  MFCBIT  32   width of one coefficient word
//  NCOEF   12   coefficients per frame
//  OWIDTH  384  packed frame width; must equal NCOEF*MFCBIT
//  GAP     16   minimum dv-low cycles between bursts; must be >=14 so the packer can finish its pack cycle
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  frame_in     in   OWIDTH  packed frame
//  frame_valid  in   1       frame_in valid
//  frame_ready  out  1       pending buffer free (= !pend_full); handshake = valid & ready at posedge
//  x_o          out  MFCBIT  coefficient word (0 when dv=0)
//  dv           out  1       word strobe; high for exactly NCOEF consecutive cycles per frame
//  done         out  1       1-cycle pulse coincident with the last word (coef NCOEF-1)
//  busy         out  1       high in SEND or GAP
// BEHAVIOUR
//  Registers
//  - pend (OWIDTH) + pend_full: one-entry holding buffer.
//  - shreg (OWIDTH): burst shift register, shifts right by MFCBIT.
//  - wcnt: 4-bit word counter. gcnt: gap counter.
//  - All outputs are registered, except frame_ready, which decodes pend_full.
//  Reset (async, rst_n=0)
//  - dv=0, x_o=0, done=0, busy=0, pend_full=0, frame_ready=1, state=IDLE, counters=0.
//  - Reset mid-burst truncates the burst immediately. The pending frame is discarded.
//  FSM states: IDLE, SEND, GAP
//  - IDLE
//    - if pend_full: load shreg<=pend, clear pend_full, state<=SEND, dv<=1, x_o<=pend[MFCBIT-1:0], wcnt<=0.
//  - SEND (one word per cycle)
//    - wcnt<NCOEF-1: x_o<=next word, wcnt++.
//    - wcnt==NCOEF-1: done=1 this cycle; next edge dv<=0, x_o<=0, gcnt<=0, state<=GAP.
//  - GAP
//    - dv held 0. gcnt++ each cycle.
//    - At gcnt==GAP-1 with pend_full: go straight to SEND (same load as IDLE).
//    - At gcnt==GAP-1 without pend_full: go to IDLE.
//    - So back-to-back frames show dv low for exactly GAP cycles.
//  Handshake
//  - Accept when frame_valid & frame_ready; pend<=frame_in, pend_full<=1.
//  - Accept and pend->shreg transfer may occur on the same edge. The pend_full set from the new accept wins.
//  - frame_ready drops the cycle after the accept. frame_in need not be held after the accept.
//  Latency
//  - Accept at edge E while IDLE and empty: pend_full seen at E, IDLE loads at E+1.
//  - dv=1 with coef0 after edge E+1. coef k appears after edge E+1+k.
//  - done is high after edge E+NCOEF.
//  Ordering: coef0 (LSBs) first, coef NCOEF-1 last. dv never has a 1-cycle low glitch inside a burst.
//  Throughput: one frame per NCOEF+GAP cycles when the buffer stays full.
//  Never drops an accepted frame. Never emits a partial burst (except on reset).
// TESTING
//  1. Reset, frame coef k=k+1, valid 1 cycle -> dv high 12 cycles, x_o=1..12, done on word 12, busy falls after 16 gap cycles.
//  2. Two frames presented back-to-back (second while first sends) -> second burst dv rises exactly 16 low cycles after first; frame_ready=0 until the second frame loads.
//  3. Third frame while pend full and bursting -> frame_ready=0, no accept; accepted after the 2nd load; three bursts in order, no loss.
//  4. rst_n low at word 5 of burst with pend full -> dv/x_o 0 asynchronously; after release nothing emitted until a new frame.
//  5. Loopback into packer: random frames, GAP=16 -> packer output equals frame_in bit-exact, one max pulse per frame.
//  6. Coef values 0xFFFFFFFF / 0x80000000 at coef0 and coef11 -> exact word at exact cycle (no shift/width truncation).

Source files
------------

// File: rtl/mfc_unpack.sv
// mfc_unpack: frame-to-stream serializer for MFCC feature frames.
// One-entry holding buffer feeds a shift register that emits one word per cycle.
module mfc_unpack #(
    parameter int MFCBIT = 32,
    parameter int NCOEF  = 12,
    parameter int OWIDTH = 384,
    parameter int GAP    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OWIDTH-1:0] frame_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [MFCBIT-1:0] x_o,
    output logic              dv,
    output logic              done,
    output logic              busy
);

    localparam int WW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [OWIDTH-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [OWIDTH-1:0] shreg_q, shreg_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [MFCBIT-1:0] x_q, x_d;
    logic              dv_q, dv_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              load;
    logic              accept;

    assign frame_ready = ~pend_full_q;
    assign x_o         = x_q;
    assign dv          = dv_q;
    assign done        = done_q;
    assign busy        = busy_q;

    // Next-state: burst sequencing, gap timing and the holding-buffer handshake.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shreg_d     = shreg_q;
        wcnt_d      = wcnt_q;
        gcnt_d      = gcnt_q;
        x_d         = x_q;
        dv_d        = dv_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        load        = 1'b0;
        accept      = frame_valid & ~pend_full_q;

        unique case (state_q)
            S_IDLE: begin
                if (pend_full_q) begin
                    load = 1'b1;
                end
            end
            S_SEND: begin
                if (wcnt_q == WW'(NCOEF - 1)) begin
                    state_d = S_GAP;
                    dv_d    = 1'b0;
                    x_d     = '0;
                    gcnt_d  = '0;
                end else begin
                    x_d     = shreg_q[MFCBIT-1:0];
                    shreg_d = shreg_q >> MFCBIT;
                    wcnt_d  = wcnt_q + 1'b1;
                    done_d  = (wcnt_q == WW'(NCOEF - 2));
                end
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP - 1)) begin
                    if (pend_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Word 0 goes straight to the output; the rest stay queued in shreg.
        if (load) begin
            state_d     = S_SEND;
            shreg_d     = pend_q >> MFCBIT;
            x_d         = pend_q[MFCBIT-1:0];
            dv_d        = 1'b1;
            busy_d      = 1'b1;
            wcnt_d      = '0;
            pend_full_d = 1'b0;
        end

        // A new accept on the same edge as a transfer keeps the buffer marked full.
        if (accept) begin
            pend_d      = frame_in;
            pend_full_d = 1'b1;
        end
    end

    // State and registered outputs; reset truncates any burst and drops the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            shreg_q     <= '0;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            x_q         <= '0;
            dv_q        <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            shreg_q     <= shreg_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            x_q         <= x_d;
            dv_q        <= dv_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mfc_unpack.sv
// tb_mfc_unpack: scoreboard bench for the MFCC frame serializer.
// Accepted frames queue their words; a negedge monitor pops and compares.
module tb_mfc_unpack;

    localparam int MFCBIT = 32;
    localparam int NCOEF  = 12;
    localparam int OWIDTH = 384;
    localparam int GAP    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [OWIDTH-1:0] frame_in = '0;
    logic              frame_valid = 1'b0;
    logic              frame_ready;
    logic [MFCBIT-1:0] x_o;
    logic              dv;
    logic              done;
    logic              busy;

    mfc_unpack #(
        .MFCBIT(MFCBIT),
        .NCOEF (NCOEF),
        .OWIDTH(OWIDTH),
        .GAP   (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .x_o        (x_o),
        .dv         (dv),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [MFCBIT-1:0] expq[$];
    int accepted = 0;
    int started = 0;
    int pos = 0;
    int lowrun = 0;
    bit seen_burst = 0;
    bit exact_gap = 0;
    bit lat_chk = 0;
    int cyc = 0;
    int acc_cyc = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    function automatic logic [OWIDTH-1:0] rnd_frame();
        logic [OWIDTH-1:0] f;
        for (int k = 0; k < NCOEF; k++) f[k*MFCBIT +: MFCBIT] = $urandom;
        return f;
    endfunction

    // Handshake observer: every accepted frame contributes NCOEF expected words.
    always @(posedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            for (int k = 0; k < NCOEF; k++)
                expq.push_back(frame_in[k*MFCBIT +: MFCBIT]);
            accepted++;
            acc_cyc = cyc;
        end
        cyc++;
    end

    // Monitor: word order, burst shape, gap length, busy and ready rules.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv) begin
                if (pos == 0) begin
                    started++;
                    if (seen_burst) begin
                        if (exact_gap) chk("gap_exact", lowrun, GAP);
                        else chk("gap_min", lowrun >= GAP, 1);
                    end
                    if (lat_chk) begin
                        chk("latency", cyc - acc_cyc, 2);
                        lat_chk = 0;
                    end
                end
                chk("word_expected", expq.size() != 0, 1);
                if (expq.size() != 0) chk($sformatf("word%0d", pos), x_o, expq.pop_front());
                chk("done", done, pos == NCOEF - 1);
                chk("busy_send", busy, 1);
                pos++;
            end else begin
                chk("x_idle", x_o, 0);
                chk("done_idle", done, 0);
                if (pos != 0) begin
                    chk("burst_len", pos, NCOEF);
                    pos = 0;
                    seen_burst = 1;
                    lowrun = 0;
                    exact_gap = (accepted > started);
                end
                lowrun++;
                chk("busy_gap", busy, seen_burst && lowrun <= GAP);
            end
            chk("frame_ready", frame_ready, accepted == started);
        end
    end

    task automatic send(input logic [OWIDTH-1:0] f);
        int a0;
        a0 = accepted;
        frame_in = f;
        frame_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (accepted != a0) break;
        end
        if (accepted == a0) chk("accept_timeout", 0, 1);
        frame_valid = 1'b0;
        frame_in = rnd_frame();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !busy && accepted == started && pos == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [OWIDTH-1:0] f;

        repeat (3) @(negedge clk);
        chk("rst_dv", dv, 0);
        chk("rst_x", x_o, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", frame_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Counting frame with latency check.
        for (int k = 0; k < NCOEF; k++) f[k*MFCBIT +: MFCBIT] = 32'(k + 1);
        lat_chk = 1;
        send(f);
        wait_idle();

        // Back-to-back pair, then three frames with a stalled third.
        send(rnd_frame());
        send(rnd_frame());
        wait_idle();
        send(rnd_frame());
        send(rnd_frame());
        send(rnd_frame());
        wait_idle();

        // Extreme words at the first and last coefficient positions.
        f = rnd_frame();
        f[0 +: MFCBIT] = 32'hFFFF_FFFF;
        f[(NCOEF-1)*MFCBIT +: MFCBIT] = 32'h8000_0000;
        send(f);
        f = rnd_frame();
        f[0 +: MFCBIT] = 32'h8000_0000;
        f[(NCOEF-1)*MFCBIT +: MFCBIT] = 32'hFFFF_FFFF;
        send(f);
        wait_idle();

        // Randomized frames with random spacing.
        repeat (20) begin
            send(rnd_frame());
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();

        // Reset mid-burst with a frame pending.
        send(rnd_frame());
        send(rnd_frame());
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pos >= 5) break;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_dv", dv, 0);
        chk("async_x", x_o, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", frame_ready, 1);
        expq.delete();
        accepted = 0;
        started = 0;
        pos = 0;
        seen_burst = 0;
        lowrun = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(rnd_frame());
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
